clk_ratio_meter: RTL

// - Measures a divided clock from the frequency divider in units of CLK cycles. Reports period and high time.
// - Lets firmware/testbench confirm the programmed division ratio and duty.
// - Sits downstream of the divider's CLK_OUT, or of any slow periodic signal in the CLK domain.
// - Results are held until acknowledged (valid/ack handshake).

---
 rtl/clk_meter_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 32 +++
 rtl/clk_ratio_meter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/clk_meter_pkg.sv
// Shared state encoding and default sizing for the clock ratio meter.
package clk_meter_pkg;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a delay flop; yields the synchronized level and a
// one-cycle pulse on each rising edge of that level.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // NOTE: sequential state uses non-blocking assignments so each flop samples
  // the pre-edge value of its neighbour and the chain shifts by one per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_dly;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow periodic signal in CLK cycles and
// holds each result behind a valid/ack handshake, with overrun and stall flags.
module clk_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             SIG_IN,
  input  logic             ACK,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             OVERRUN,
  output logic             STALL
);

  localparam int               WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_t     r_state;
  meter_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [WD_W-1:0]  r_wdog;
  logic             r_stall;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_overrun;

  logic             w_s;
  logic             w_rise;
  logic             w_active;
  logic             w_timeout;
  logic             w_result;

  sync_edge_det u_sync (
    .clk     (CLK),
    .rst     (RESET),
    .i_d     (SIG_IN),
    .o_level (w_s),
    .o_rise  (w_rise)
  );

  assign w_active  = (r_state == ST_ARM) || (r_state == ST_MEASURE);
  // A rise always wins over an expiring watchdog in the same cycle.
  assign w_timeout = w_active && !w_rise && (r_wdog == WD_LAST);
  assign w_result  = ENABLE && (r_state == ST_MEASURE) && w_rise;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred
  // latches on paths that leave the state unchanged.
  always_comb begin
    w_state_nxt = r_state;
    if (!ENABLE) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_ARM;
        ST_ARM:     if (w_rise) w_state_nxt = ST_MEASURE;
        ST_MEASURE: if (w_timeout) w_state_nxt = ST_ARM;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Period/high counters, watchdog and stall flag; all cleared while disabled.
  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      r_cnt   <= '0;
      r_hcnt  <= '0;
      r_wdog  <= '0;
      r_stall <= 1'b0;
    end else if (w_active) begin
      if (w_rise) begin
        r_cnt   <= CNT_W'(1);
        r_hcnt  <= CNT_W'(w_s);
        r_wdog  <= '0;
        r_stall <= 1'b0;
      end else if (w_timeout) begin
        // Watchdog holds at its last value so STALL persists until a rise.
        r_cnt   <= '0;
        r_hcnt  <= '0;
        r_stall <= 1'b1;
      end else begin
        r_wdog <= r_wdog + WD_W'(1);
        if (r_state == ST_MEASURE) begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_s && (r_hcnt != CNT_MAX)) begin
            r_hcnt <= r_hcnt + CNT_W'(1);
          end
        end
      end
    end else begin
      r_cnt  <= '0;
      r_hcnt <= '0;
      r_wdog <= '0;
    end
  end

  // Result registers and handshake; a coincident ACK consumes the old result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_result) begin
      r_period <= r_cnt;
      r_high   <= r_hcnt;
      r_valid  <= 1'b1;
      if (r_valid && !ACK) begin
        r_overrun <= 1'b1;
      end
    end else if (ACK && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign PERIOD    = r_period;
  assign HIGH_TIME = r_high;
  assign VALID     = r_valid;
  assign OVERRUN   = r_overrun;
  assign STALL     = r_stall;

endmodule
